// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the 256-byte S memory in place using the key.
// One byte read or write per cycle on a single-port memory with one-cycle read latency.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_SI,
    WT_SI,
    RD_SJ,
    WT_SJ,
    WR_I,
    WR_J
  } state_t;

  state_t                 state_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i_q;
  logic [7:0]             j_q;
  logic [KW-1:0]          k_q;
  logic [7:0]             si_q;
  logic [7:0]             addr_q;
  logic [7:0]             wrdata_q;
  logic                   wren_q;
  logic                   rdy_q;

  // Byte 0 of the key is the most significant byte.
  logic [7:0] kb [KEY_BYTES];
  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_kb
    assign kb[g] = key_q[8*(KEY_BYTES-1-g) +: 8];
  end

  logic [7:0] kbyte;
  logic [7:0] j_d;
  always_comb begin
    kbyte = kb[k_q];
    j_d   = j_q + rddata + kbyte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          wren_q <= 1'b0;
          rdy_q  <= 1'b1;
          if (en) begin
            key_q   <= key;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            rdy_q   <= 1'b0;
            state_q <= RD_SI;
          end
        end
        RD_SI: state_q <= WT_SI;
        WT_SI: begin
          // Address for the S[j] read is the freshly updated j.
          si_q    <= rddata;
          j_q     <= j_d;
          addr_q  <= j_d;
          state_q <= RD_SJ;
        end
        RD_SJ: state_q <= WT_SJ;
        WT_SJ: begin
          addr_q   <= i_q;
          wrdata_q <= rddata;
          wren_q   <= 1'b1;
          state_q  <= WR_I;
        end
        WR_I: begin
          addr_q   <= j_q;
          wrdata_q <= si_q;
          wren_q   <= 1'b1;
          state_q  <= WR_J;
        end
        WR_J: begin
          wren_q <= 1'b0;
          if (i_q == 8'hFF) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            i_q     <= i_q + 8'd1;
            addr_q  <= i_q + 8'd1;
            k_q     <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            state_q <= RD_SI;
          end
        end
        default: begin
          wren_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdy    = rdy_q;
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule
